// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle for piso_serializer.
// master: the side that offers words and consumes the serial stream.
// slave:  the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid_i;
    logic [WIDTH-1:0] data_i;
    logic             load_ready_o;
    logic             x_o;
    logic             x_valid_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output load_valid_i,
        output data_i,
        input  load_ready_o,
        input  x_o,
        input  x_valid_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  load_valid_i,
        input  data_i,
        output load_ready_o,
        output x_o,
        output x_valid_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready word loading.
// A captured word is emitted one bit per cycle starting the cycle after the
// load handshake; a new word may be accepted in the last-bit cycle so frames
// stream back-to-back with no gap.
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append an even-parity
// bit (XOR of the captured word) after the last data bit of every frame.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic             w_last;
    logic             w_ready;
    logic             w_load;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;
    logic             w_bit;

    // r_cnt holds how many bits of the frame have been presented, including
    // the one currently on x_o, so the last-bit cycle is r_cnt == N.
    assign w_last  = (r_state == SHIFT) && (r_cnt == CW'(N));
    assign w_ready = (r_state == IDLE) || w_last;
    assign w_load  = bus.load_valid_i && w_ready;

    // Bit order only changes which end of the register is presented and the
    // direction it moves; the vacated position is filled with zero.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_head    = r_shift[WIDTH-1];
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = r_shift[0];
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

`ifdef PISO_SERIALIZER_PARITY_EN
    logic r_parity;

    // Even parity of the word is latched at capture; it rides as the final bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^bus.data_i;
        end
    end

    assign w_bit = w_last ? r_parity : w_head;
`else
    assign w_bit = w_head;
`endif

    // State register; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on a load, leave SHIFT only when the last bit
    // goes out with no replacement word waiting.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !w_load) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shift register and bit counter: reload on handshake, advance otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= bus.data_i;
            r_cnt   <= CW'(1);
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.load_ready_o = w_ready;
    assign bus.busy_o       = (r_state == SHIFT);
    assign bus.x_valid_o    = (r_state == SHIFT);
    assign bus.x_o          = (r_state == SHIFT) ? w_bit : 1'b0;
    assign bus.done_o       = w_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share the same
// stimulus; a scoreboard queue holds the expected serial bits of both.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk;
    logic reset;

    piso_serializer_if #(.WIDTH(4)) if_m ();
    piso_serializer_if #(.WIDTH(4)) if_l ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m.slave)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [3:0] seq_m;   // expected MSB-first order, leftmost bit sent first
        logic [3:0] seq_l;   // expected LSB-first order, leftmost bit sent first
        logic       par;
    } vec_t;

    typedef struct packed {
        logic xm;
        logic xl;
        logic last;
    } exp_t;

    vec_t tbl [8];
    exp_t q [$];

    int checks = 0;
    int errors = 0;

    logic [3:0] cur_seq_m;
    logic [3:0] cur_seq_l;
    logic       cur_par;
    bit         junk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic [3:0] data);
        if_m.load_valid_i = valid;
        if_m.data_i       = data;
        if_l.load_valid_i = valid;
        if_l.data_i       = data;
    endtask

    // One clock cycle: check outputs at the falling edge against the
    // scoreboard, record a pending handshake, return 1 time unit after the
    // next rising edge so the caller can drive new inputs.
    task automatic step(output bit hs);
        exp_t e;
        logic exp_ready;
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("x_valid_m", if_m.x_valid_o, 1'b1);
            chk("x_valid_l", if_l.x_valid_o, 1'b1);
            chk("busy", if_m.busy_o, 1'b1);
            chk("x_msb", if_m.x_o, e.xm);
            chk("x_lsb", if_l.x_o, e.xl);
            chk("done_m", if_m.done_o, e.last);
            chk("done_l", if_l.done_o, e.last);
            exp_ready = e.last;
        end else begin
            chk("x_valid_idle", if_m.x_valid_o, 1'b0);
            chk("busy_idle", if_m.busy_o, 1'b0);
            chk("x_idle", if_m.x_o, 1'b0);
            chk("done_idle", if_m.done_o | if_l.done_o, 1'b0);
            exp_ready = 1'b1;
        end
        chk("ready_m", if_m.load_ready_o, exp_ready);
        chk("ready_l", if_l.load_ready_o, exp_ready);
        hs = if_m.load_valid_i && if_m.load_ready_o;
        if (hs) begin
            if (junk) begin
                chk("junk_accepted", 1'b1, 1'b0);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    e.xm   = cur_seq_m[3-k];
                    e.xl   = cur_seq_l[3-k];
                    e.last = (k == NB - 1);
                    q.push_back(e);
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                e.xm   = cur_par;
                e.xl   = cur_par;
                e.last = 1'b1;
                q.push_back(e);
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i);
        cur_seq_m = tbl[i].seq_m;
        cur_seq_l = tbl[i].seq_l;
        cur_par   = tbl[i].par;
        junk      = 1'b0;
        drive(1'b1, tbl[i].data);
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit hs;
        int budget;
        int idx;

        tbl[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
        tbl[1] = '{4'b1100, 4'b1100, 4'b0011, 1'b0};
        tbl[2] = '{4'b0011, 4'b0011, 4'b1100, 1'b0};
        tbl[3] = '{4'b1001, 4'b1001, 4'b1001, 1'b0};
        tbl[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[6] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
        tbl[7] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};

        junk = 1'b0;
        cur_seq_m = '0;
        cur_seq_l = '0;
        cur_par = 1'b0;
        reset = 1'b1;
        drive(1'b0, 4'b0000);

        // Reset state.
        @(negedge clk);
        chk("rst_x_valid", if_m.x_valid_o, 1'b0);
        chk("rst_busy", if_m.busy_o, 1'b0);
        chk("rst_done", if_m.done_o, 1'b0);
        chk("rst_x", if_m.x_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(hs);
        $display("reset released, idle checked");

        // Isolated frames from the table, with idle gaps between them.
        for (int i = 0; i < 8; i++) begin
            set_vec(i);
            budget = 20;
            hs = 1'b0;
            while (!hs && budget > 0) begin
                step(hs);
                budget--;
            end
            if (!hs) chk("load_timeout", 1'b0, 1'b1);
            drive(1'b0, 4'b0000);
            for (int c = 0; c < NB + 2; c++) step(hs);
            $display("single frame data=%b msb_seq=%b lsb_seq=%b par=%b", tbl[i].data, tbl[i].seq_m, tbl[i].seq_l, tbl[i].par);
        end

        // Zero-gap streaming with valid held high; data is scrambled in every
        // cycle the block is not ready so captures out of turn show up.
        idx = 0;
        budget = 200;
        while (idx < 8 && budget > 0) begin
            if (if_m.load_ready_o) begin
                set_vec(idx);
            end else begin
                junk = 1'b1;
                drive(1'b1, 4'($urandom_range(0, 15)));
            end
            step(hs);
            if (hs && !junk) begin
                $display("streamed word %0d data=%b", idx, tbl[idx].data);
                idx++;
            end
            budget--;
        end
        if (idx != 8) chk("stream_timeout", 1'b0, 1'b1);
        junk = 1'b0;
        drive(1'b0, 4'b0000);
        for (int c = 0; c < NB + 2; c++) step(hs);

        // Reset in the second bit cycle of a 1111 frame.
        set_vec(4);
        budget = 20;
        hs = 1'b0;
        while (!hs && budget > 0) begin
            step(hs);
            budget--;
        end
        if (!hs) chk("load_timeout_rst", 1'b0, 1'b1);
        drive(1'b0, 4'b0000);
        step(hs);                 // bit 1 checked; now bit 2 is on x_o
        #2;
        reset = 1'b1;
        #1;
        chk("async_x_valid_m", if_m.x_valid_o, 1'b0);
        chk("async_x_valid_l", if_l.x_valid_o, 1'b0);
        chk("async_busy", if_m.busy_o, 1'b0);
        chk("async_done", if_m.done_o | if_l.done_o, 1'b0);
        q.delete();
        drive(1'b1, 4'b1010);     // must not be captured while reset is high
        @(posedge clk);
        #1;
        chk("no_load_in_reset", if_m.x_valid_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 4'b0000);
        @(posedge clk);
        #1;
        for (int c = 0; c < NB + 1; c++) step(hs);
        $display("mid-frame reset aborted frame, idle after release");

        // One more frame after reset proves the block recovered.
        set_vec(0);
        budget = 20;
        hs = 1'b0;
        while (!hs && budget > 0) begin
            step(hs);
            budget--;
        end
        if (!hs) chk("load_timeout_post", 1'b0, 1'b1);
        drive(1'b0, 4'b0000);
        for (int c = 0; c < NB + 2; c++) step(hs);
        $display("post-reset frame data=%b", tbl[0].data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of data bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = data_i[WIDTH-1] transmitted first, 0 = data_i[0] first.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_valid_i  input  1  parallel word offered.
REQ-006 SHALL have port data_i  input  WIDTH  parallel word, sampled at handshake.
REQ-007 SHALL have port load_ready_o  output  1  block can accept a word this cycle.
REQ-008 SHALL have port x_o  output  1  serial output bit.
REQ-009 SHALL have port x_valid_o  output  1  x_o carries a valid bit.
REQ-010 SHALL have port busy_o  output  1  frame in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse on last bit of frame.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT.
REQ-013 Handshake SHALL occur on a rising edge where load_valid_i=1 and load_ready_o=1; data_i SHALL be captured into an internal WIDTH-bit shift register.
REQ-014 load_ready_o SHALL be 1 in IDLE and in the last-bit cycle of SHIFT; 0 otherwise (combinational from state/counter, not from load_valid_i).
REQ-015 IDLE + handshake -> SHIFT; first bit SHALL appear on x_o with x_valid_o=1 in the cycle after the handshake edge (latency 1).
REQ-016 In SHIFT, one bit SHALL be presented per cycle, in order given by MSB_FIRST; frame length N = WIDTH (WIDTH+1 with parity, REQ-028).
REQ-017 A bit counter of ceil(log2(N+1)) bits SHALL count presented bits; no wrap beyond N.
REQ-018 done_o SHALL be 1 exactly in the cycle the last bit of the frame is on x_o.
REQ-019 Last-bit cycle with handshake: SHALL remain in SHIFT, reload word, counter restart; next frame's first bit on the very next cycle (zero-gap streaming).
REQ-020 Last-bit cycle without handshake: SHALL return to IDLE.
REQ-021 In IDLE: x_o=0, x_valid_o=0, busy_o=0, done_o=0.
REQ-022 busy_o SHALL equal 1 whenever state is SHIFT.
REQ-023 load_valid_i/data_i changes while load_ready_o=0 SHALL be ignored and SHALL NOT disturb the frame in progress.

Reset
REQ-024 Reset assertion SHALL force IDLE immediately (asynchronously), regardless of clk.
REQ-025 Reset values: load_ready_o=1 after state=IDLE, x_o=0, x_valid_o=0, busy_o=0, done_o=0, shift register=0, counter=0.
REQ-026 Reset mid-frame SHALL abort the frame; remaining bits SHALL never be emitted and no done_o pulse SHALL occur.
REQ-027 While reset is high, handshakes SHALL NOT be accepted.

Configuration
REQ-028 With macro PISO_SERIALIZER_PARITY_EN defined, an even-parity bit (XOR of captured word) SHALL follow the last data bit, N=WIDTH+1, done_o on the parity bit.
REQ-029 Without PISO_SERIALIZER_PARITY_EN, no parity logic SHALL exist and N=WIDTH.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1, load 4'b1011 at edge 0 -> x_o 1,0,1,1 on cycles 1..4, x_valid_o=1 cycles 1..4, done_o only cycle 4, IDLE cycle 5.
REQ-031 Back-to-back: load 4'b1100 then 4'b0011 during its last-bit cycle -> x_o 1,1,0,0,0,0,1,1 with no gap, done_o cycles 4 and 8.
REQ-032 Hold load_valid_i=1 with data_i changing every cycle during a frame of 4'b1001 -> output stays 1,0,0,1; next word taken only at last-bit cycle.
REQ-033 Assert reset during cycle 2 of frame 4'b1111 -> x_valid_o=0, busy_o=0 immediately, no done_o, load_ready_o=1 after release.
REQ-034 MSB_FIRST=0, load 4'b1011 -> x_o 1,1,0,1.
REQ-035 PISO_SERIALIZER_PARITY_EN defined, load 4'b1011 -> x_o 1,0,1,1,1, done_o on cycle 5; load 4'b1001 -> parity bit 0.
